bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the datapath bus multiplexer.
- Turns per-source bus-drive requests from the control logic into the registered one-hot 32-bit select vector that the bus consumes.
- Guarantees that at most one source drives the bus per cycle.
- Provides fair rotation among requesters and bounded multi-cycle ownership.

Parameters:
- N_SRC, 24, number of bus sources; request/grant bit i maps to bus input i.
- CTRL_W, 32, width of the bus select vector; bits N_SRC..CTRL_W-1 are always 0.
- IDX_W, 5, width of the encoded grant index; must satisfy 2**IDX_W >= N_SRC.
- MAX_HOLD, 4, maximum consecutive cycles one source keeps the grant while any other source is requesting.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- req  input  N_SRC  per-source request; bit i high = source i wants to drive the bus.
- BusCtrl  output  CTRL_W  registered one-hot (or all-zero) bus select; feeds the bus control input.
- grant_valid  output  1  high when exactly one BusCtrl bit is set.
- grant_idx  output  IDX_W  binary index of the granted source; 0 when grant_valid is low.
- hold_cnt  output  3  cycles the current owner has held the grant (debug/verification visibility).

Behaviour:
- Reset: clear low asynchronously forces, without waiting for a clock edge:
  - BusCtrl = 0, grant_valid = 0, grant_idx = 0, hold_cnt = 0
  - rotation pointer ptr = 0, state = IDLE
- Reset asserted mid-grant drops the grant immediately.
- First grant after release of clear: first edge on which req != 0.
- States: IDLE, OWN.
- IDLE:
  - req == 0: stay in IDLE, outputs zero.
  - req != 0: winner = first set bit scanning ptr, ptr+1, …, N_SRC-1, 0, …, ptr-1.
  - On that edge: BusCtrl[winner] = 1, grant_idx = winner, grant_valid = 1, hold_cnt = 1, ptr = (winner+1) mod N_SRC, go to OWN.
- OWN, per edge with owner o:
  - req[o] = 0 and other req set: hand off directly to the next winner (scan from ptr) on the same edge, with no idle bus cycle. hold_cnt = 1, ptr updated.
  - req[o] = 0 and req == 0: BusCtrl = 0, grant_valid = 0, grant_idx = 0, hold_cnt = 0, go to IDLE.
  - req[o] = 1 and no other req: keep the grant. hold_cnt saturates at MAX_HOLD.
  - req[o] = 1, another req set, hold_cnt < MAX_HOLD: keep the grant, hold_cnt += 1.
  - req[o] = 1, another req set, hold_cnt == MAX_HOLD: force a handoff to the next winner scanning from ptr, excluding o. hold_cnt = 1.
- Latency: a request is reflected in BusCtrl one clock edge after it is sampled. The arbiter does not drive combinationally from req.
- Wrap-around: ptr advances 23 -> 0. The scan wraps modulo N_SRC. A source at ptr-1 has the lowest priority.
- Invariants, every cycle:
  - popcount(BusCtrl) <= 1.
  - BusCtrl[CTRL_W-1:N_SRC] == 0.
  - grant_valid == |BusCtrl.
  - grant_idx == encoded BusCtrl.
- Simultaneous requests: exactly one winner per the rotation rule. The others wait, and each is served within (N_SRC-1)*MAX_HOLD cycles.
- Request bits for indices >= N_SRC do not exist. Any X on req bits is not propagated as multiple grants; the bench treats X on req as illegal stimulus.

Test Plan:
- Reset/idle: clear=0 for 2 cycles with req=24'hFFFFFF -> BusCtrl=0, grant_valid=0, grant_idx=0 throughout. Release clear -> BusCtrl=32'h1 and grant_idx=0 one edge later.
- Single request latency: req=24'h000020 after reset -> BusCtrl=32'h00000020, grant_idx=5, hold_cnt=1 on the next edge. Drop req -> BusCtrl=0, grant_valid=0 on the following edge.
- Round-robin fairness: req=24'h000111 (sources 0,4,8), each grant dropped after one cycle by clearing the winner's bit and re-setting it next cycle -> grant order 0,4,8,0,4,8. Never two bits set.
- MAX_HOLD preemption: req[3] and req[7] held high continuously -> 3 owns for 4 cycles (hold_cnt 1..4), then 7 for 4 cycles, then 3. Handoff edges show no zero-BusCtrl cycle.
- Wrap-around: ptr at 23 (prior grant to 22), req = bits 23 and 1 -> grant 23 first, then 1. Starting from a grant to 23 with req = bits 0 and 23 -> next winner 0.
- Reset mid-grant: owner 12 active, assert clear between edges -> BusCtrl=0 immediately, before the next edge. After release with req[12] and req[2] set -> grant 2 first (ptr=0).
- Sweep: drive each one-hot req in turn, i = 0..23 -> BusCtrl === (1<<i) and grant_idx === i, one edge after each request.

Source files
------------

// File: rtl/bus_grant_arbiter_if.sv
// Bus-drive request/grant bundle between the control logic (master side)
// and the round-robin grant arbiter (slave side).
interface bus_grant_arbiter_if #(
  parameter int N_SRC  = 24,
  parameter int CTRL_W = 32,
  parameter int IDX_W  = 5
) ();
  logic [N_SRC-1:0]  req;
  logic [CTRL_W-1:0] BusCtrl;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [2:0]        hold_cnt;

  // Control logic: raises requests, observes the grant.
  modport master (
    output req,
    input  BusCtrl,
    input  grant_valid,
    input  grant_idx,
    input  hold_cnt
  );

  // Arbiter: consumes requests, produces the registered grant.
  modport slave (
    input  req,
    output BusCtrl,
    output grant_valid,
    output grant_idx,
    output hold_cnt
  );
endinterface

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter. It produces a registered one-hot select
// for the datapath bus mux. An owner keeps the bus for at most MAX_HOLD
// consecutive cycles while anyone else is waiting. Handoffs happen on the
// same edge, so the bus never has an idle cycle between two owners.
module bus_grant_arbiter #(
  parameter int N_SRC    = 24,
  parameter int CTRL_W   = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              clear,
  bus_grant_arbiter_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [2:0]       MAX_HOLD_C = 3'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_SRC   = IDX_W'(N_SRC - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CTRL_W-1:0] busctrl_q, busctrl_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        hold_q, hold_d;
  logic              valid_q, valid_d;

  logic [CTRL_W-1:0] req_ext;
  logic [N_SRC-1:0]  others;
  logic              own_req;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic              grant_new;

  // The first set bit of r, scanning p, p+1, ... and wrapping modulo N_SRC.
  // The result is {found, index}.
  function automatic logic [IDX_W:0] rr_scan(input logic [N_SRC-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      c = int'(p) + k;
      if (c >= N_SRC) c = c - N_SRC;
      // Descending k lets the candidate nearest to p overwrite the others.
      if (r[c]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  // Decode the request vector against the current owner. The owner is
  // excluded from the scan, so a forced handoff never picks it again.
  // In IDLE the owner mask is zero, so the scan covers every requester.
  always_comb begin
    req_ext      = '0;
    req_ext[N_SRC-1:0] = bus.req;
    own_req      = (state_q == OWN) && req_ext[idx_q];
    others       = bus.req & ~busctrl_q[N_SRC-1:0];
    {found, win} = rr_scan(others, ptr_q);
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busctrl_d = busctrl_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    grant_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) grant_new = 1'b1;
      end
      OWN: begin
        if (!own_req) begin
          if (found) begin
            grant_new = 1'b1;
          end else begin
            state_d   = IDLE;
            busctrl_d = '0;
            idx_d     = '0;
            hold_d    = '0;
            valid_d   = 1'b0;
          end
        end else if (!found) begin
          // Sole requester: keep the bus, count saturates.
          if (hold_q != MAX_HOLD_C) hold_d = hold_q + 3'd1;
        end else if (hold_q < MAX_HOLD_C) begin
          hold_d = hold_q + 3'd1;
        end else begin
          grant_new = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d   = OWN;
      busctrl_d = CTRL_W'(1) << win;
      idx_d     = win;
      hold_d    = 3'd1;
      valid_d   = 1'b1;
      ptr_d     = (win == LAST_SRC) ? '0 : win + IDX_W'(1);
    end
  end

  // Grant registers. Clear drops the grant without waiting for a clock.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      busctrl_q <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busctrl_q <= busctrl_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.BusCtrl     = busctrl_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
  assign bus.hold_cnt    = hold_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed testbench for bus_grant_arbiter. All expected values are hand-computed.
module tb_bus_grant_arbiter;

  localparam int N_SRC  = 24;
  localparam int CTRL_W = 32;
  localparam int IDX_W  = 5;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_err;

  bus_grant_arbiter_if #(.N_SRC(N_SRC), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) bus ();

  bus_grant_arbiter #(
    .N_SRC(N_SRC), .CTRL_W(CTRL_W), .IDX_W(IDX_W), .MAX_HOLD(4)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear   = 1'b0;
    bus.req = '0;
    step();
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear   = 1'b0;
    bus.req = 24'hFFFFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (bus.BusCtrl !== 32'h0 || bus.grant_valid !== 1'b0 ||
          bus.grant_idx !== 5'd0 || bus.hold_cnt !== 3'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: BusCtrl=%h gv=%b idx=%0d hold=%0d, want 0/0/0/0",
                 c, bus.BusCtrl, bus.grant_valid, bus.grant_idx, bus.hold_cnt);
      end
    end
    clear = 1'b1;
    step();
    n_cmp++;
    if (bus.BusCtrl !== 32'h1 || bus.grant_idx !== 5'd0 || bus.grant_valid !== 1'b1 ||
        bus.hold_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL reset_release: BusCtrl=%h idx=%0d gv=%b hold=%0d, want 00000001/0/1/1",
               bus.BusCtrl, bus.grant_idx, bus.grant_valid, bus.hold_cnt);
    end
    $display("test_reset: done, BusCtrl=%h", bus.BusCtrl);
  endtask

  task automatic test_single_latency();
    do_reset();
    bus.req = 24'h000020;
    #1;
    n_cmp++;
    if (bus.BusCtrl !== 32'h0) begin
      n_err++;
      $display("FAIL single_no_comb: BusCtrl=%h before edge, want 00000000", bus.BusCtrl);
    end
    step();
    n_cmp++;
    if (bus.BusCtrl !== 32'h00000020 || bus.grant_idx !== 5'd5 || bus.hold_cnt !== 3'd1 ||
        bus.grant_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: BusCtrl=%h idx=%0d hold=%0d gv=%b, want 00000020/5/1/1",
               bus.BusCtrl, bus.grant_idx, bus.hold_cnt, bus.grant_valid);
    end
    bus.req = '0;
    step();
    n_cmp++;
    if (bus.BusCtrl !== 32'h0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 5'd0 ||
        bus.hold_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL single_release: BusCtrl=%h gv=%b idx=%0d hold=%0d, want 0/0/0/0",
               bus.BusCtrl, bus.grant_valid, bus.grant_idx, bus.hold_cnt);
    end
    $display("test_single_latency: done");
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 4, 8, 0, 4, 8};
    logic [CTRL_W-1:0] exp_bus;
    do_reset();
    bus.req = 24'h000111;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_bus = CTRL_W'(1) << exp_order[k];
      n_cmp++;
      if (bus.BusCtrl !== exp_bus || bus.grant_idx !== IDX_W'(exp_order[k]) ||
          $countones(bus.BusCtrl) > 1) begin
        n_err++;
        $display("FAIL rr_order k=%0d: BusCtrl=%h idx=%0d, want %h/%0d",
                 k, bus.BusCtrl, bus.grant_idx, exp_bus, exp_order[k]);
      end
      $display("rr k=%0d granted %0d", k, bus.grant_idx);
      // The winner drops its bit for one cycle and the others stay requesting.
      bus.req = 24'h000111 & ~(24'h1 << exp_order[k]);
    end
  endtask

  task automatic test_max_hold();
    int exp_own  [9] = '{3, 3, 3, 3, 7, 7, 7, 7, 3};
    int exp_hold [9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
    do_reset();
    bus.req = 24'h000088;
    for (int k = 0; k < 9; k++) begin
      step();
      n_cmp++;
      if (bus.BusCtrl !== (CTRL_W'(1) << exp_own[k]) ||
          bus.hold_cnt !== 3'(exp_hold[k]) || bus.grant_valid !== 1'b1) begin
        n_err++;
        $display("FAIL max_hold k=%0d: BusCtrl=%h hold=%0d gv=%b, want owner %0d hold %0d",
                 k, bus.BusCtrl, bus.hold_cnt, bus.grant_valid, exp_own[k], exp_hold[k]);
      end
      $display("hold k=%0d owner=%0d hold_cnt=%0d", k, bus.grant_idx, bus.hold_cnt);
    end
    bus.req = '0;
  endtask

  task automatic test_wraparound();
    do_reset();
    bus.req = 24'h1 << 22;
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd22) begin
      n_err++;
      $display("FAIL wrap_setup22: idx=%0d, want 22", bus.grant_idx);
    end
    bus.req = (24'h1 << 23) | 24'h2;
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd23 || bus.BusCtrl !== 32'h00800000) begin
      n_err++;
      $display("FAIL wrap_first23: idx=%0d BusCtrl=%h, want 23/00800000", bus.grant_idx, bus.BusCtrl);
    end
    bus.req = 24'h2;
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd1 || bus.BusCtrl !== 32'h2) begin
      n_err++;
      $display("FAIL wrap_then1: idx=%0d BusCtrl=%h, want 1/00000002", bus.grant_idx, bus.BusCtrl);
    end
    $display("wrap part1: 23 then %0d", bus.grant_idx);

    // Owner 23 with source 0 waiting: 23 holds to MAX_HOLD, then the scan wraps to 0.
    do_reset();
    bus.req = 24'h1 << 23;
    step();
    bus.req = (24'h1 << 23) | 24'h1;
    for (int k = 2; k <= 4; k++) begin
      step();
      n_cmp++;
      if (bus.grant_idx !== 5'd23 || bus.hold_cnt !== 3'(k)) begin
        n_err++;
        $display("FAIL wrap_hold23 k=%0d: idx=%0d hold=%0d, want 23/%0d",
                 k, bus.grant_idx, bus.hold_cnt, k);
      end
    end
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd0 || bus.BusCtrl !== 32'h1 || bus.hold_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL wrap_to0: idx=%0d BusCtrl=%h hold=%0d, want 0/00000001/1",
               bus.grant_idx, bus.BusCtrl, bus.hold_cnt);
    end
    $display("wrap part2: after 23 granted %0d", bus.grant_idx);
    bus.req = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 24'h1 << 12;
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd12) begin
      n_err++;
      $display("FAIL mid_setup12: idx=%0d, want 12", bus.grant_idx);
    end
    #2;
    clear = 1'b0;
    #1;
    n_cmp++;
    if (bus.BusCtrl !== 32'h0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 5'd0 ||
        bus.hold_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: BusCtrl=%h gv=%b idx=%0d hold=%0d, want 0/0/0/0",
               bus.BusCtrl, bus.grant_valid, bus.grant_idx, bus.hold_cnt);
    end
    bus.req = (24'h1 << 12) | (24'h1 << 2);
    step();
    clear = 1'b1;
    step();
    n_cmp++;
    if (bus.grant_idx !== 5'd2 || bus.BusCtrl !== 32'h4) begin
      n_err++;
      $display("FAIL mid_after_release: idx=%0d BusCtrl=%h, want 2/00000004", bus.grant_idx, bus.BusCtrl);
    end
    $display("reset mid grant: after release granted %0d", bus.grant_idx);
    bus.req = '0;
  endtask

  task automatic test_sweep();
    do_reset();
    for (int i = 0; i < N_SRC; i++) begin
      bus.req = 24'h1 << i;
      step();
      n_cmp++;
      if (bus.BusCtrl !== (CTRL_W'(1) << i) || bus.grant_idx !== IDX_W'(i) ||
          bus.grant_valid !== 1'b1 || bus.BusCtrl[CTRL_W-1:N_SRC] !== 8'h0) begin
        n_err++;
        $display("FAIL sweep i=%0d: BusCtrl=%h idx=%0d gv=%b, want %h/%0d/1",
                 i, bus.BusCtrl, bus.grant_idx, bus.grant_valid, CTRL_W'(1) << i, i);
      end
      $display("sweep i=%0d BusCtrl=%h", i, bus.BusCtrl);
    end
    bus.req = '0;
    step();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clear   = 1'b0;
    bus.req = '0;
    test_reset();
    test_single_latency();
    test_round_robin();
    test_max_hold();
    test_wraparound();
    test_reset_mid_grant();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
